// File: rtl/arm_pkg.sv
// Shared constants and helpers for the fetch stage and its memory.
// Exports NOP_INSTR, PC_STEP and clog2().
package arm_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Handshake/bus bundle between the hazard/execute/loader side and if_stage.
// master drives stall, redirect and memory load; slave drives IF/ID outputs.
interface if_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_Freeze;
    logic                  i_Sig_Branch_Taken;
    logic [DATA_WIDTH-1:0] i_Branch_Address;
    logic                  i_Imem_Write_Enable;
    logic [ADDR_WIDTH-1:0] i_Imem_Write_Address;
    logic [DATA_WIDTH-1:0] i_Imem_Write_Data;
    logic [DATA_WIDTH-1:0] o_Pc;
    logic [DATA_WIDTH-1:0] o_Instruction;
    logic                  o_Valid;
    logic [DATA_WIDTH-1:0] o_Fetch_Pc;

    modport master (
        output i_Freeze, i_Sig_Branch_Taken, i_Branch_Address,
        output i_Imem_Write_Enable, i_Imem_Write_Address, i_Imem_Write_Data,
        input  o_Pc, o_Instruction, o_Valid, o_Fetch_Pc
    );

    modport slave (
        input  i_Freeze, i_Sig_Branch_Taken, i_Branch_Address,
        input  i_Imem_Write_Enable, i_Imem_Write_Address, i_Imem_Write_Data,
        output o_Pc, o_Instruction, o_Valid, o_Fetch_Pc
    );
endinterface

// File: rtl/if_stage_instruction_memory.sv
// Word-addressed instruction memory: combinational read, synchronous write.
// Ports: clk, we/waddr/wdata (write), raddr (word index) -> rdata.
module instruction_memory
    import arm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_WIDTH = clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-3:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [IMEM_DEPTH];
    logic                  out_of_range;

    // Contents are never cleared; loads may happen at any time.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Any set bit above the index field means the address is past the end.
    assign out_of_range = |raddr[DATA_WIDTH-3:ADDR_WIDTH];
    assign rdata = out_of_range ? DATA_WIDTH'(NOP_INSTR)
                                : mem[raddr[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, instruction memory read, IF/ID register.
// Ports: clk, reset (sync, active-high), bus (if_stage_if.slave).
module if_stage
    import arm_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     IMEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);

    localparam int ADDR_WIDTH = clog2(IMEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_instr;
    logic                  id_valid;
    logic                  unused_pc_lsb;

    // Fetch ignores the byte offset within a word.
    assign unused_pc_lsb = ^pc[1:0];
    assign pc_plus4 = pc + STEP;

    instruction_memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMEM_DEPTH(IMEM_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_imem (
        .clk  (clk),
        .we   (bus.i_Imem_Write_Enable),
        .waddr(bus.i_Imem_Write_Address),
        .wdata(bus.i_Imem_Write_Data),
        .raddr(pc[DATA_WIDTH-1:2]),
        .rdata(fetch_word)
    );

    // Redirect beats freeze: a taken branch both moves the PC and
    // flushes IF/ID even when the hazard unit is stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            id_pc    <= '0;
            id_instr <= NOP;
            id_valid <= 1'b0;
        end else if (bus.i_Sig_Branch_Taken) begin
            pc       <= bus.i_Branch_Address;
            id_pc    <= '0;
            id_instr <= NOP;
            id_valid <= 1'b0;
        end else if (!bus.i_Freeze) begin
            pc       <= pc_plus4;
            id_pc    <= pc_plus4;
            id_instr <= fetch_word;
            id_valid <= 1'b1;
        end
    end

    assign bus.o_Pc          = id_pc;
    assign bus.o_Instruction = id_instr;
    assign bus.o_Valid       = id_valid;
    assign bus.o_Fetch_Pc    = pc;

endmodule
